// File: rtl/euler_seq_multiplier_pkg.sv
// euler_seq_multiplier_pkg: FSM state encodings and default widths shared by the Euler datapath blocks.
package euler_seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_SIZE      = 8;
    localparam int DEF_FRAC_BITS = 4;

endpackage

// File: rtl/euler_seq_multiplier_fxp_sat_trunc.sv
// fxp_sat_trunc: rescales an unsigned double-width magnitude and applies a sign, saturating to SIZE bits.
module fxp_sat_trunc
    import euler_seq_multiplier_pkg::*;
#(
    parameter int SIZE      = DEF_SIZE,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic [2*SIZE-1:0] mag_in,
    input  logic              sign,
    output logic [SIZE-1:0]   product,
    output logic              ovf
);

    logic [2*SIZE-1:0] mag;
    logic              over_pos;
    logic              over_neg;

    // Dropping fraction bits of the magnitude rounds toward zero for both signs.
    assign mag      = mag_in >> FRAC_BITS;
    assign over_pos = |mag[2*SIZE-1:SIZE-1];
    assign over_neg = (|mag[2*SIZE-1:SIZE]) || (mag[SIZE-1] && (|mag[SIZE-2:0]));
    assign ovf      = sign ? over_neg : over_pos;
    assign product  = !ovf ? (sign ? -mag[SIZE-1:0] : mag[SIZE-1:0])
                    : sign ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};

endmodule

// File: rtl/euler_seq_multiplier.sv
// euler_seq_multiplier: radix-2 shift-add signed fixed-point multiplier with saturating output.
module euler_seq_multiplier
    import euler_seq_multiplier_pkg::*;
#(
    parameter int SIZE      = DEF_SIZE,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic            clk,
    input  logic            rst_async,
    input  logic            rst_sync,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            busy,
    output logic            done_mul,
    output logic [SIZE-1:0] product,
    output logic            ovf
);

    localparam int            CW   = $clog2(SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2*SIZE-1:0] mcand;
    logic [2*SIZE-1:0] acc;
    logic [2*SIZE-1:0] acc_nxt;
    logic [SIZE-1:0]   mplier;
    logic [SIZE-1:0]   a_abs;
    logic [SIZE-1:0]   b_abs;
    logic [SIZE-1:0]   prod_sat;
    logic              sign;
    logic              ovf_sat;

    // Unsigned reading of the negated most-negative value gives its true magnitude.
    assign a_abs    = a[SIZE-1] ? -a : a;
    assign b_abs    = b[SIZE-1] ? -b : b;
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
    assign busy     = state == RUN;
    assign done_mul = state == DONE;

    fxp_sat_trunc #(.SIZE(SIZE), .FRAC_BITS(FRAC_BITS)) u_sat (
        .mag_in  (acc_nxt),
        .sign    (sign),
        .product (prod_sat),
        .ovf     (ovf_sat)
    );

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            sign    <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else if (!rst_sync) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            sign    <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else if (state == RUN) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                state   <= DONE;
                product <= prod_sat;
                ovf     <= ovf_sat;
            end
        end else if (start) begin
            state  <= RUN;
            sign   <= a[SIZE-1] ^ b[SIZE-1];
            mcand  <= {{SIZE{1'b0}}, a_abs};
            mplier <= b_abs;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_euler_seq_multiplier.sv
// tb_euler_seq_multiplier: randomized and directed checks of the multiplier against a cycle-level model.
module tb_euler_seq_multiplier;

    logic       clk = 1'b0;
    logic       rst_async = 1'b1;
    logic       rst_sync = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy, done_mul, ovf;
    logic [7:0] product;

    int         tests = 0;
    int         fails = 0;
    bit         chk_en = 1'b0;

    int         left = 0;
    logic       m_done = 1'b0;
    logic [7:0] m_prod = 8'h00;
    logic       m_ovf = 1'b0;
    logic [8:0] pend = 9'h000;

    always #5 clk = ~clk;

    euler_seq_multiplier dut (
        .clk       (clk),
        .rst_async (rst_async),
        .rst_sync  (rst_sync),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done_mul  (done_mul),
        .product   (product),
        .ovf       (ovf)
    );

    // Returns {ovf, product} from plain integer arithmetic on Q4.4 values.
    function automatic logic [8:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int sx, sy, m;
        bit neg;
        logic [7:0] r;
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        neg = (sx < 0) != (sy < 0);
        m   = ((sx < 0) ? -sx : sx) * ((sy < 0) ? -sy : sy) / 16;
        if (!neg && m > 127) return {1'b1, 8'h7F};
        if (neg && m > 128) return {1'b1, 8'h80};
        r = 8'(neg ? -m : m);
        return {1'b0, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a multiply is a countdown of 8 cycles after acceptance, then one done cycle.
    always @(posedge clk or posedge rst_async) begin
        if (rst_async || !rst_sync) begin
            left = 0;
            m_done = 1'b0;
            m_prod = 8'h00;
            m_ovf = 1'b0;
        end else if (left > 0) begin
            left--;
            m_done = (left == 0);
            if (left == 0) {m_ovf, m_prod} = pend;
        end else begin
            m_done = 1'b0;
            if (start) begin
                pend = ref_mul(a, b);
                left = 8;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en)
            check("cycle {busy,done,ovf,product}", {21'b0, busy, done_mul, ovf, product},
                  {21'b0, left > 0, m_done, m_ovf, m_prod});
    end

    task automatic wait_done(input string name, input logic [8:0] exp, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!done_mul && n < 20);
        if (!done_mul) begin
            tests++;
            fails++;
            $display("FAIL %s: done_mul did not rise within 20 cycles", name);
        end else begin
            check(name, {23'b0, ovf, product}, {23'b0, exp});
        end
    endtask

    task automatic op(input string name, input logic [7:0] x, input logic [7:0] y, input logic [8:0] exp);
        int n;
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        wait_done(name, exp, n);
        check({name, " latency"}, n, 8);
    endtask

    task automatic pulse_start(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n, last, pulses;
        bit seen;
        logic [7:0] corner [5];
        corner = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00};

        repeat (3) @(negedge clk);
        check("reset state", {24'b0, busy, done_mul, ovf, product[4:0]}, 32'h0);
        check("reset product", {24'b0, product}, 32'h0);
        chk_en = 1'b1;
        rst_async = 1'b0;

        check("model 1.5*2", ref_mul(8'h18, 8'h20), 9'h030);
        check("model -8*-8", ref_mul(8'h80, 8'h80), 9'h17F);
        check("model -1/16*1/16", ref_mul(8'hFF, 8'h01), 9'h000);
        check("model -8*1", ref_mul(8'h80, 8'h10), 9'h080);

        op("1.5*2.0", 8'h18, 8'h20, 9'h030);
        op("-1.5*2.0", 8'hE8, 8'h20, 9'h0D0);
        op("-8*1", 8'h80, 8'h10, 9'h080);
        op("7*2 sat", 8'h70, 8'h20, 9'h17F);
        op("-8*-8 sat", 8'h80, 8'h80, 9'h17F);
        op("tiny pos", 8'h01, 8'h01, 9'h000);
        op("tiny neg", 8'hFF, 8'h01, 9'h000);
        op("-8*1.0625 sat", 8'h80, 8'h11, 9'h180);

        pulse_start(8'h18, 8'h20);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a = 8'h70;
        b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        wait_done("start during run ignored", 9'h030, n);

        last = -1;
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (done_mul) begin
                if (last >= 0) check("back-to-back period", i - last, 9);
                last = i;
                pulses++;
            end
            @(negedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
        end
        start = 1'b0;
        check("back-to-back pulse count", pulses, 4);
        repeat (12) @(negedge clk);

        pulse_start(8'h18, 8'h20);
        repeat (3) @(negedge clk);
        rst_sync = 1'b0;
        @(negedge clk);
        check("sync reset busy/product", {23'b0, busy, product}, 32'h0);
        rst_sync = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= done_mul;
        end
        check("sync reset no done", {31'b0, seen}, 32'h0);
        op("after sync reset", 8'hE8, 8'h20, 9'h0D0);

        pulse_start(8'h70, 8'h10);
        repeat (3) @(negedge clk);
        rst_async = 1'b1;
        #1;
        check("async reset busy/product", {23'b0, busy, product}, 32'h0);
        @(negedge clk);
        rst_async = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= done_mul;
        end
        check("async reset no done", {31'b0, seen}, 32'h0);
        op("after async reset", 8'h18, 8'h20, 9'h030);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(3) == 0);
            a = ($urandom_range(4) == 0) ? corner[$urandom_range(4)] : 8'($urandom);
            b = ($urandom_range(4) == 0) ? corner[$urandom_range(4)] : 8'($urandom);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
